// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and sizes for the truth table sequencer.
// Sweeps 16 input vectors through an external evaluator.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int VEC_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter timing how long a vector settles.
// expired is high in the last settle cycle of a vector.
module tt_settle_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Load on vector entry, count down while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == LAST_VAL);

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives all 16 vectors into an external 4-input evaluator,
// captures its truth table and compares against a golden one.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] expected_i,
  input  logic        f_i,
  output logic [3:0]  vec_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] table_o,
  output logic [4:0]  ones_o,
  output logic        match_o
);

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]     idx;
  logic [VEC_COUNT-1:0] tbl;
  logic [CNT_W-1:0]     ones;
  logic                 match;
  logic                 tmr_load;
  logic                 tmr_en;
  logic                 tmr_expired;
  logic                 last;
  logic                 go;

  assign last = (idx == IDX_W'(VEC_COUNT - 1));
  assign go   = start_i && !abort_i;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; abort wins everywhere outside IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (abort_i)          state_nxt = IDLE;
        else if (tmr_expired) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (abort_i)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
        else           state_nxt = SETTLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs and timer control decoded from the state.
  always_comb begin
    busy_o   = (state != IDLE);
    done_o   = (state == DONE);
    vec_o    = (state == IDLE) ? '0 : idx;
    tmr_en   = (state == SETTLE);
    tmr_load = (state_nxt == SETTLE) && (state != SETTLE);
  end

  // Vector index, captured table, ones count and match flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      tbl   <= '0;
      ones  <= '0;
      match <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            idx   <= '0;
            tbl   <= '0;
            ones  <= '0;
            match <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort_i) match <= 1'b0;
        end
        CAPTURE: begin
          if (abort_i) begin
            match <= 1'b0;
          end else begin
            tbl[idx] <= f_i;
            ones     <= ones + CNT_W'(f_i);
            if (!last) idx <= idx + 1'b1;
          end
        end
        DONE: begin
          match <= abort_i ? 1'b0 : (tbl == expected_i);
        end
      endcase
    end
  end

  assign table_o = tbl;
  assign ones_o  = ones;
  assign match_o = match;

endmodule
